// File: rtl/gray2bin_iq_sched_if.sv
// gray2bin_iq_sched_if: symbol in, shared-converter link, symbol out and status of the I/Q scheduler
// Ports: s_* = Gray symbol in (ready/valid), conv_* = shared gray2bin lane,
// m_* = reassembled binary symbol out (ready/valid), err/sym_count = status.
// slave = scheduler side, master = environment side.
interface gray2bin_iq_sched_if #(parameter int B = 2);
  logic [B-1:0] s_gray_i, s_gray_q, conv_gray, conv_bin;
  logic [2*B-1:0] m_bin;
  logic [15:0] sym_count;
  logic s_valid, s_ready, conv_i_dv, conv_o_dv, m_valid, m_ready, err;
  modport slave (
    input s_gray_i, s_gray_q, s_valid, conv_bin, conv_o_dv, m_ready,
    output s_ready, conv_gray, conv_i_dv, m_bin, m_valid, err, sym_count
  );
  modport master (
    output s_gray_i, s_gray_q, s_valid, conv_bin, conv_o_dv, m_ready,
    input s_ready, conv_gray, conv_i_dv, m_bin, m_valid, err, sym_count
  );
endinterface

// File: rtl/gray2bin_iq_sched.sv
// gray2bin_iq_sched: time-multiplexes one gray2bin lane between the I and Q axes of a QAM symbol
// Ports: clk, rst (sync, active-high); bus (slave): s_* Gray symbol in, conv_* shared converter,
// m_* {bin_i, bin_q} out, err sticky protocol/timeout error, sym_count delivered symbols mod 2^16.
module gray2bin_iq_sched #(
  parameter int MODULATION_ORDER = 16,
  parameter int CONV_LATENCY = 1,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  gray2bin_iq_sched_if.slave bus
);
  localparam int B = $clog2(MODULATION_ORDER) / 2;
  localparam int LIMIT = CONV_LATENCY + TIMEOUT + 2;
  localparam int WW = $clog2(LIMIT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE_I, ISSUE_Q, WAIT, OUT} state_t;
  state_t state_q, state_d;
  logic [B-1:0] gray_q_q, gray_q_d, conv_gray_q, conv_gray_d;
  logic [B-1:0] bin_i_q, bin_i_d, bin_q_q, bin_q_d;
  logic [1:0] ret_cnt_q, ret_cnt_d, ret_cnt_n;
  logic [WW-1:0] wd_q, wd_d;
  logic [15:0] sym_count_q, sym_count_d;
  logic err_q, err_d;
  logic busy, take, accept, deliver, timeout;
  always_comb begin
    busy = state_q inside {ISSUE_I, ISSUE_Q, WAIT};
    take = busy && ret_cnt_q != 2'd2 && bus.conv_o_dv;
    accept = state_q == IDLE && bus.s_valid;
    deliver = state_q == OUT && bus.m_ready;
    ret_cnt_n = ret_cnt_q + {1'b0, take};
    // a second return landing on the expiry edge still completes the symbol
    timeout = state_q == WAIT && wd_q == WW'(LIMIT - 1) && ret_cnt_n != 2'd2;
    ret_cnt_d = (deliver || timeout) ? 2'd0 : ret_cnt_n;
    gray_q_d = accept ? bus.s_gray_q : gray_q_q;
    // conv_gray is a register so it holds its last value outside the issue cycles
    conv_gray_d = accept ? bus.s_gray_i : state_q == ISSUE_I ? gray_q_q : conv_gray_q;
    bin_i_d = take && ret_cnt_q == 2'd0 ? bus.conv_bin : bin_i_q;
    bin_q_d = take && ret_cnt_q == 2'd1 ? bus.conv_bin : bin_q_q;
    wd_d = accept ? '0 : busy ? wd_q + 1'b1 : wd_q;
    err_d = err_q || timeout || (bus.conv_o_dv && !take);
    sym_count_d = sym_count_q + {15'd0, deliver};
    state_d = state_q;
    case (state_q)
      IDLE: state_d = accept ? ISSUE_I : IDLE;
      ISSUE_I: state_d = ISSUE_Q;
      ISSUE_Q: state_d = ret_cnt_n == 2'd2 ? OUT : WAIT;
      WAIT: state_d = ret_cnt_n == 2'd2 ? OUT : timeout ? IDLE : WAIT;
      OUT: state_d = deliver ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gray_q_q <= '0;
      conv_gray_q <= '0;
      bin_i_q <= '0;
      bin_q_q <= '0;
      ret_cnt_q <= '0;
      wd_q <= '0;
      err_q <= 1'b0;
      sym_count_q <= '0;
    end else begin
      state_q <= state_d;
      gray_q_q <= gray_q_d;
      conv_gray_q <= conv_gray_d;
      bin_i_q <= bin_i_d;
      bin_q_q <= bin_q_d;
      ret_cnt_q <= ret_cnt_d;
      wd_q <= wd_d;
      err_q <= err_d;
      sym_count_q <= sym_count_d;
    end
  end
  assign bus.s_ready = state_q == IDLE;
  assign bus.m_valid = state_q == OUT;
  assign bus.conv_i_dv = state_q inside {ISSUE_I, ISSUE_Q};
  assign bus.conv_gray = conv_gray_q;
  assign bus.m_bin = {bin_i_q, bin_q_q};
  assign bus.err = err_q;
  assign bus.sym_count = sym_count_q;
endmodule

// File: tb/tb_gray2bin_iq_sched.sv
// tb_gray2bin_iq_sched: vector table, directed corner sequences and random scoreboard for the I/Q scheduler
module tb_gray2bin_iq_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic conv_en = 1'b1;
  logic inj = 1'b0;
  logic cv_dv = 1'b0;
  logic cv16_dv = 1'b0;
  logic [2:0] cv_bin = '0;
  logic [1:0] cv16_bin = '0;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic [2:0] gi;
    logic [2:0] gq;
    logic [5:0] bin;
  } vec_t;
  vec_t tbl[5];
  logic [5:0] exp_q[$];
  always #5 clk = ~clk;
  gray2bin_iq_sched_if #(.B(3)) bus ();
  gray2bin_iq_sched_if #(.B(2)) bus16 ();
  gray2bin_iq_sched #(.MODULATION_ORDER(64), .CONV_LATENCY(1), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  gray2bin_iq_sched #(.MODULATION_ORDER(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] b = '0;
    for (int i = 0; i < 8; i++) b ^= g >> i;
    return b;
  endfunction
  always @(posedge clk) begin
    cv_dv <= !rst && conv_en && bus.conv_i_dv;
    cv_bin <= 3'(g2b(8'(bus.conv_gray)));
    cv16_dv <= !rst && bus16.conv_i_dv;
    cv16_bin <= 2'(g2b(8'(bus16.conv_gray)));
  end
  assign bus.conv_o_dv = cv_dv | inj;
  assign bus.conv_bin = cv_bin;
  assign bus16.conv_o_dv = cv16_dv;
  assign bus16.conv_bin = cv16_bin;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_s_ready"}, 32'(bus.s_ready), 32'd1);
    chk({tag, "_m_valid"}, 32'(bus.m_valid), 32'd0);
    chk({tag, "_m_bin"}, 32'(bus.m_bin), 32'd0);
    chk({tag, "_conv_i_dv"}, 32'(bus.conv_i_dv), 32'd0);
    chk({tag, "_conv_gray"}, 32'(bus.conv_gray), 32'd0);
    chk({tag, "_err"}, 32'(bus.err), 32'd0);
    chk({tag, "_sym_count"}, 32'(bus.sym_count), 32'd0);
  endtask
  task automatic xfer(input logic [2:0] gi, input logic [2:0] gq, output logic [5:0] got, output logic ok, output int lat);
    bus.s_gray_i = gi;
    bus.s_gray_q = gq;
    bus.s_valid = 1'b1;
    step();
    bus.s_valid = 1'b0;
    ok = 1'b0;
    got = '0;
    lat = -1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (bus.m_valid) begin
        ok = 1'b1;
        got = bus.m_bin;
        lat = i;
      end
      step();
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
  initial begin
    logic [5:0] got, expv;
    logic ok, mv_seen, acc;
    int lat, sent, got_n, last, cyc;
    tbl[0] = '{3'b011, 3'b001, 6'b010_001};
    tbl[1] = '{3'b100, 3'b111, 6'b111_101};
    tbl[2] = '{3'b110, 3'b010, 6'b100_011};
    tbl[3] = '{3'b000, 3'b101, 6'b000_110};
    tbl[4] = '{3'b010, 3'b100, 6'b011_111};
    bus.s_valid = 1'b0;
    bus.s_gray_i = '0;
    bus.s_gray_q = '0;
    bus.m_ready = 1'b1;
    bus16.s_valid = 1'b0;
    bus16.s_gray_i = '0;
    bus16.s_gray_q = '0;
    bus16.m_ready = 1'b1;
    step(3);
    chk_reset("rst0");
    chk("rst0_16_s_ready", 32'(bus16.s_ready), 32'd1);
    chk("rst0_16_m_bin", 32'(bus16.m_bin), 32'd0);
    chk("rst0_16_conv_gray", 32'(bus16.conv_gray), 32'd0);
    rst = 1'b0;
    step();
    bus16.s_gray_i = 2'b11;
    bus16.s_gray_q = 2'b01;
    bus16.s_valid = 1'b1;
    step();
    bus16.s_valid = 1'b0;
    chk("m16_c1_dv", 32'(bus16.conv_i_dv), 32'd1);
    chk("m16_c1_gray", 32'(bus16.conv_gray), 32'h3);
    step();
    chk("m16_c2_dv", 32'(bus16.conv_i_dv), 32'd1);
    chk("m16_c2_gray", 32'(bus16.conv_gray), 32'h1);
    step();
    chk("m16_c3_dv", 32'(bus16.conv_i_dv), 32'd0);
    chk("m16_c3_mv", 32'(bus16.m_valid), 32'd0);
    step();
    chk("m16_c4_mv", 32'(bus16.m_valid), 32'd1);
    chk("m16_c4_bin", 32'(bus16.m_bin), 32'b1001);
    step();
    chk("m16_c5_cnt", 32'(bus16.sym_count), 32'd1);
    chk("m16_c5_rdy", 32'(bus16.s_ready), 32'd1);
    chk("m16_c5_mv", 32'(bus16.m_valid), 32'd0);
    foreach (tbl[k]) begin
      xfer(tbl[k].gi, tbl[k].gq, got, ok, lat);
      chk("tbl_done", 32'(ok), 32'd1);
      chk("tbl_bin", 32'(got), 32'(tbl[k].bin));
      chk("tbl_lat", 32'(lat), 32'd3);
    end
    chk("tbl_cnt", 32'(bus.sym_count), 32'd5);
    bus.m_ready = 1'b0;
    bus.s_gray_i = 3'b101;
    bus.s_gray_q = 3'b110;
    bus.s_valid = 1'b1;
    step();
    bus.s_gray_i = 3'b000;
    expv = {3'(g2b(8'b101)), 3'(g2b(8'b110))};
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (bus.m_valid) ok = 1'b1;
      else step();
    end
    chk("bp_mv", 32'(ok), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_bin", 32'(bus.m_bin), 32'(expv));
      chk("bp_mv_hold", 32'(bus.m_valid), 32'd1);
      chk("bp_s_ready", 32'(bus.s_ready), 32'd0);
      chk("bp_conv_i_dv", 32'(bus.conv_i_dv), 32'd0);
      step();
    end
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b0;
    step();
    chk("bp_rel_mv", 32'(bus.m_valid), 32'd0);
    chk("bp_rel_rdy", 32'(bus.s_ready), 32'd1);
    chk("bp_rel_cnt", 32'(bus.sym_count), 32'd6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    sent = 0;
    got_n = 0;
    last = -1;
    cyc = 0;
    acc = 1'b0;
    bus.s_gray_i = 3'($urandom);
    bus.s_gray_q = 3'($urandom);
    bus.s_valid = 1'b1;
    while (got_n < 100 && cyc < 2000) begin
      if (acc) begin
        bus.s_gray_i = 3'($urandom);
        bus.s_gray_q = 3'($urandom);
        if (sent == 100) bus.s_valid = 1'b0;
      end
      acc = 1'b0;
      if (bus.m_valid) begin
        if (exp_q.size() == 0) chk("rnd_unexpected_out", 32'd1, 32'd0);
        else chk("rnd_bin", 32'(bus.m_bin), 32'(exp_q.pop_front()));
        if (last >= 0) chk("rnd_gap", 32'(cyc - last), 32'd5);
        last = cyc;
        got_n++;
      end
      if (bus.s_valid && bus.s_ready) begin
        exp_q.push_back({3'(g2b(8'(bus.s_gray_i))), 3'(g2b(8'(bus.s_gray_q)))});
        sent++;
        acc = 1'b1;
      end
      step();
      cyc++;
    end
    chk("rnd_n", 32'(got_n), 32'd100);
    chk("rnd_cnt", 32'(bus.sym_count), 32'd100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    conv_en = 1'b0;
    bus.s_gray_i = 3'b001;
    bus.s_gray_q = 3'b010;
    bus.s_valid = 1'b1;
    step();
    bus.s_valid = 1'b0;
    mv_seen = 1'b0;
    for (int i = 1; i < 19; i++) begin
      mv_seen |= bus.m_valid;
      step();
    end
    chk("wd_c19_err", 32'(bus.err), 32'd0);
    chk("wd_c19_rdy", 32'(bus.s_ready), 32'd0);
    mv_seen |= bus.m_valid;
    step();
    chk("wd_err", 32'(bus.err), 32'd1);
    chk("wd_rdy", 32'(bus.s_ready), 32'd1);
    chk("wd_mv", 32'(bus.m_valid | mv_seen), 32'd0);
    chk("wd_cnt", 32'(bus.sym_count), 32'd0);
    conv_en = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    inj = 1'b1;
    step();
    inj = 1'b0;
    chk("inj_err", 32'(bus.err), 32'd1);
    chk("inj_mv", 32'(bus.m_valid), 32'd0);
    chk("inj_rdy", 32'(bus.s_ready), 32'd1);
    xfer(tbl[1].gi, tbl[1].gq, got, ok, lat);
    chk("inj_next_done", 32'(ok), 32'd1);
    chk("inj_next_bin", 32'(got), 32'(tbl[1].bin));
    chk("inj_next_cnt", 32'(bus.sym_count), 32'd1);
    bus.s_gray_i = 3'b110;
    bus.s_gray_q = 3'b011;
    bus.s_valid = 1'b1;
    step();
    bus.s_valid = 1'b0;
    step(2);
    chk("rw_busy", 32'(bus.s_ready), 32'd0);
    chk("rw_mv", 32'(bus.m_valid), 32'd0);
    rst = 1'b1;
    step();
    chk_reset("rw");
    rst = 1'b0;
    xfer(tbl[2].gi, tbl[2].gq, got, ok, lat);
    chk("rw_next_done", 32'(ok), 32'd1);
    chk("rw_next_bin", 32'(got), 32'(tbl[2].bin));
    chk("rw_next_cnt", 32'(bus.sym_count), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gray2bin_iq_sched.md
# gray2bin_iq_sched

Time-multiplexing scheduler that shares one `gray2bin` lane between the I and Q axes of a QAM demapper. It accepts one Gray-coded symbol (I and Q halves) per handshake and issues I, then Q, to the shared converter. It collects both binary results in order and presents the reassembled binary symbol on a ready/valid output. It sits between the slicer and the bit deinterleaver and halves converter area at the cost of throughput.

## Interface
- `MODULATION_ORDER`, default 16: QAM order. `B = $clog2(MODULATION_ORDER)/2` bits per axis.
- `CONV_LATENCY`, default 1: nominal converter latency in cycles (≥1). Used only for the watchdog limit.
- `TIMEOUT`, default 16: extra cycles allowed beyond `CONV_LATENCY` before the watchdog fires.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset. The shared converter is on the same reset.
- `s_gray_i` in B: I-axis Gray code.
- `s_gray_q` in B: Q-axis Gray code.
- `s_valid` in 1: input symbol valid.
- `s_ready` out 1: scheduler can accept a symbol.
- `conv_gray` out B: to converter `gray_code`.
- `conv_i_dv` out 1: to converter `i_dv`.
- `conv_bin` in B: from converter `binary_code`.
- `conv_o_dv` in 1: from converter `o_dv`.
- `m_bin` out 2B: `{bin_i, bin_q}`.
- `m_valid` out 1: output symbol valid.
- `m_ready` in 1: downstream accepts.
- `err` out 1: sticky protocol error. Cleared only by `rst`.
- `sym_count` out 16: symbols delivered, modulo 2^16.

## Operation
- FSM states: IDLE, ISSUE_I, ISSUE_Q, WAIT, OUT.
- IDLE:
  - `s_ready=1`.
  - On `s_valid&&s_ready`, register `s_gray_i`/`s_gray_q` and go to ISSUE_I.
- ISSUE_I: `conv_gray=gray_i`, `conv_i_dv=1` for exactly one cycle, then go to ISSUE_Q.
- ISSUE_Q: `conv_gray=gray_q`, `conv_i_dv=1` for exactly one cycle, then go to WAIT.
- Return capture runs independently of state while returns are outstanding (`ret_cnt<2`):
  - First `conv_o_dv` loads `bin_i`.
  - Second `conv_o_dv` loads `bin_q`.
  - Returns can arrive during ISSUE_Q or WAIT.
- From WAIT (or from ISSUE_Q if both returns are already captured), enter OUT on the edge where `ret_cnt` reaches 2.
- OUT: `m_valid=1`, with `m_bin` held stable until `m_ready`. On `m_valid&&m_ready`:
  - increment `sym_count` (wraps 0xFFFF→0),
  - clear `ret_cnt`,
  - go to IDLE.
- Outside ISSUE_I/ISSUE_Q: `conv_i_dv=0` and `conv_gray` holds its last value.
- Watchdog:
  - The cycle counter starts in ISSUE_I.
  - If `ret_cnt<2` after `CONV_LATENCY+TIMEOUT+2` cycles, set `err`, drop the symbol, clear `ret_cnt` and return to IDLE. No `m_valid` is produced.
- Unexpected return: `conv_o_dv` while no return is outstanding (IDLE, OUT, or `ret_cnt==2`) sets `err`. The data is ignored and the state is unchanged.
- `s_ready` and `m_valid` are decoded from state only, with no combinational input→output paths.
- The block is one symbol deep: no new symbol is accepted until OUT completes.

## Timing
- Reset values:
  - state IDLE,
  - `s_ready=1`,
  - `m_valid=0`,
  - `m_bin=0`,
  - `conv_i_dv=0`,
  - `conv_gray=0`,
  - `err=0`,
  - `sym_count=0`,
  - `ret_cnt=0`.
- Cycle numbering, with the accept edge at the end of cycle 0:
  - ISSUE_I in cycle 1, ISSUE_Q in cycle 2.
  - For latency L, returns are sampled in cycles 1+L and 2+L.
  - `m_valid` rises in cycle 3+L. For L=1, that is cycle 4.
- With `m_ready` held high, throughput is one symbol per 4+L cycles. `s_ready` reasserts the cycle after the output handshake.
- Backpressure: `m_valid`/`m_bin` stay constant for any number of cycles with `m_ready=0`. `s_ready` stays 0 throughout.
- Reset mid-operation:
  - Takes effect on the next edge.
  - The held symbol and any partially captured results are discarded.
  - `err` is cleared.
  - The converter flushes on the same reset, so no stale return follows.

## Test plan
- M=16 (B=2), L=1, `s_gray_i=2'b11`, `s_gray_q=2'b01`, `m_ready=1` -> `conv_i_dv` pulses in cycles 1 and 2 with `conv_gray` 11 then 01. `m_valid` in cycle 4 with `m_bin=4'b1001`, and `sym_count=1`.
- Back-to-back symbols with `s_valid` held high, M=64 (B=3), 100 random symbols -> every `m_bin` equals `{g2b(I),g2b(Q)}` in input order. Spacing is 5 cycles and `sym_count=100`.
- Hold `m_ready=0` for 10 cycles in OUT -> `m_bin` is stable, `s_ready=0`, and no `conv_i_dv` occurs. The handshake on the release cycle returns the FSM to IDLE.
- Stub converter never asserts `conv_o_dv`, default parameters -> `err=1` after 19 cycles counted from ISSUE_I, `m_valid` never asserts, `s_ready=1` the next cycle, and `sym_count` is unchanged.
- Inject `conv_o_dv` while IDLE -> `err=1`, no `m_valid`, and the next symbol still converts correctly.
- Assert `rst` for one cycle during WAIT after one return -> all outputs are at reset values next cycle, and a fresh symbol then completes normally with `sym_count=1`.
